// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader:
// loader state encoding and default memory geometry.
package imem_loader_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 12;
  localparam int DEFAULT_DEPTH      = 4096;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    CHK,
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Little-endian byte-to-word assembler: shifts accepted bytes in LSB first and
// flags the load strobe that completes a 32-bit word.
module imem_loader_byte_assembler (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  // Only the three earlier bytes need storing; the fourth is taken straight
  // from the input as it is accepted.
  logic [23:0] shift_q;
  logic [1:0]  byte_idx_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_q    <= '0;
      byte_idx_q <= '0;
    end else if (load_i) begin
      shift_q    <= {byte_i, shift_q[23:8]};
      byte_idx_q <= byte_idx_q + 1'b1;
    end
  end

  assign word_o       = {byte_i, shift_q};
  assign word_valid_o = load_i && (byte_idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> consecutive imem words, holding the CPU until done.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_wren,
  output logic [ADDR_WIDTH-1:0] imem_address,
  output logic [31:0]           imem_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err
);

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_e                state_q;
  logic                  in_ready_q;
  logic                  wren_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           data_q;
  logic                  hold_q;
  logic                  done_q;
  logic                  err_q;
  logic [7:0]            len_lo_q;
  // One bit wider than the address so a full-depth image terminates cleanly.
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   word_ptr_q;
  logic [ADDR_WIDTH:0]   word_ptr_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            chk_q;
`endif

  logic        accept;
  logic        asm_load;
  logic        word_valid;
  logic [31:0] word;
  logic [15:0] len_word;

  assign accept     = in_valid && in_ready_q;
  assign asm_load   = accept && (state_q == DATA);
  assign len_word   = {in_data, len_lo_q};
  assign word_ptr_d = word_ptr_q + 1'b1;

  imem_loader_byte_assembler u_asm (
    .clock        (clock),
    .reset        (reset),
    .load_i       (asm_load),
    .byte_i       (in_data),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= LEN_LO;
      in_ready_q <= 1'b1;
      wren_q     <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      len_lo_q   <= '0;
      len_q      <= '0;
      word_ptr_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      case (state_q)
        LEN_LO: begin
          if (accept) begin
            len_lo_q <= in_data;
            state_q  <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len_q <= len_word[ADDR_WIDTH:0];
            if (len_word == 16'd0) begin
              state_q    <= DONE;
              in_ready_q <= 1'b0;
              hold_q     <= 1'b0;
              done_q     <= 1'b1;
            end else if ({1'b0, len_word} > DEPTH_W) begin
              state_q    <= ERR;
              in_ready_q <= 1'b0;
              err_q      <= 1'b1;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q <= chk_q ^ in_data;
`endif
            if (word_valid) begin
              state_q    <= WRITE;
              in_ready_q <= 1'b0;
              wren_q     <= 1'b1;
              addr_q     <= word_ptr_q[ADDR_WIDTH-1:0];
              data_q     <= word;
            end
          end
        end
        WRITE: begin
          wren_q     <= 1'b0;
          word_ptr_q <= word_ptr_d;
          if (word_ptr_d == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_q    <= CHK;
            in_ready_q <= 1'b1;
`else
            state_q    <= DONE;
            hold_q     <= 1'b0;
            done_q     <= 1'b1;
`endif
          end else begin
            state_q    <= DATA;
            in_ready_q <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            if (in_data == chk_q) begin
              state_q <= DONE;
              hold_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end
          end
        end
`endif
        DONE, ERR: begin
        end
        default: begin
          state_q    <= ERR;
          in_ready_q <= 1'b0;
          err_q      <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign imem_wren    = wren_q;
  assign imem_address = addr_q;
  assign imem_data    = data_q;
  assign cpu_hold     = hold_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader; expected writes are queued by the
// stimulus side and consumed by an independent strobe monitor.
module tb_imem_loader;

  localparam int AW    = 12;
  localparam int DEPTH = 4096;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          imem_wren;
  logic [AW-1:0] imem_address;
  logic [31:0]   imem_data;
  logic          cpu_hold;
  logic          done;
  logic          err;

  always #5 clock = ~clock;

  imem_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_wren    (imem_wren),
    .imem_address (imem_address),
    .imem_data    (imem_data),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] img_words[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          last_evt = 0;
  bit          mon_en   = 0;
  logic        prev_done = 1'b0;
  logic        prev_err  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every strobe must match the oldest queued write; done/err must rise
  // in the cycle right after the last accepted byte or the last write strobe.
  always @(negedge clock) begin
    if (mon_en && !reset) begin
      if (in_valid && in_ready) last_evt = cyc + 1;
      if (imem_wren) begin
        last_evt = cyc + 1;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL stray_strobe: write @0x%0h data 0x%0h, expected none", imem_address, imem_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", 32'(imem_address), 32'(mon_e.addr));
          check("wr_data", imem_data, mon_e.data);
        end
      end
      if (done && !prev_done) check("done_rise_cycle", cyc, last_evt);
      if (err && !prev_err)   check("err_rise_cycle", cyc, last_evt);
    end
    prev_done = done;
    prev_err  = err;
  end

  // Asynchronous reset asserted mid-cycle; outputs must reset before the next edge.
  task automatic do_reset();
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    reset    = 1'b1;
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_wren", 32'(imem_wren), 32'd0);
    check("rst_address", 32'(imem_address), 32'd0);
    check("rst_data", imem_data, 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_pending_writes", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset  = 1'b0;
    mon_en = 1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int min_gap, input int max_gap, output bit ok);
    int t;
    int g;
    g = int'($urandom_range(max_gap, min_gap));
    in_valid = 1'b0;
    repeat (g) begin
      @(posedge clock);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clock);
      #1;
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_accept_timeout: in_ready=0 after %0d cycles, expected 1", t);
      in_valid = 1'b0;
      ok = 0;
      return;
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    ok = 1;
  endtask

  task automatic fill_random(input int n);
    img_words.delete();
    for (int i = 0; i < n; i++) img_words.push_back($urandom);
  endtask

  // Reference model: builds the byte stream and expected writes/status from the image.
  task automatic run_image(input int n, input bit bad_chk, input int min_gap, input int max_gap);
    logic [7:0] bytes[$];
    logic [7:0] x;
    logic [31:0] w;
    bit exp_err;
    bit ok;
    bit seen;
    int t;
    do_reset();
    x = 8'h00;
    bytes.push_back(n[7:0]);
    bytes.push_back(n[15:8]);
    exp_err = (n > DEPTH);
    if (!exp_err) begin
      for (int i = 0; i < n; i++) begin
        w = img_words[i];
        for (int k = 0; k < 4; k++) begin
          bytes.push_back(w[8*k +: 8]);
          x = x ^ w[8*k +: 8];
        end
        exp_q.push_back('{addr: AW'(i), data: w});
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (!exp_err && n > 0) begin
      bytes.push_back(bad_chk ? (x ^ 8'h01) : x);
      exp_err = bad_chk;
    end
`endif
    foreach (bytes[i]) begin
      send_byte(bytes[i], min_gap, max_gap, ok);
      if (!ok) break;
    end
    t = 0;
    while (!(done || err) && t < 50) begin
      @(posedge clock);
      #1;
      t++;
    end
    check("load_finished", 32'(done || err), 32'd1);
    repeat (2) @(posedge clock);
    #1;
    check("done", 32'(done), 32'(!exp_err));
    check("err", 32'(err), 32'(exp_err));
    check("cpu_hold", 32'(cpu_hold), 32'(exp_err));
    check("in_ready_after", 32'(in_ready), 32'd0);
    check("writes_pending", 32'(exp_q.size()), 32'd0);
    seen = 0;
    in_valid = 1'b1;
    repeat (4) begin
      in_data = 8'($urandom);
      @(posedge clock);
      #1;
      if (in_ready) seen = 1;
    end
    in_valid = 1'b0;
    check("extra_byte_ready", 32'(seen), 32'd0);
    check("status_sticky", 32'({done, err}), exp_err ? 32'd1 : 32'd2);
    $display("image n=%0d gaps=%0d..%0d bad_chk=%0b -> done=%0b err=%0b cpu_hold=%0b",
             n, min_gap, max_gap, bad_chk, done, err, cpu_hold);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    int r;

    img_words = '{32'h00200013, 32'h0040000A};
    run_image(2, 0, 0, 0);
    run_image(0, 0, 0, 2);
    run_image(4097, 0, 0, 0);
    img_words = '{32'hDEADBEEF};
    run_image(1, 0, 1, 1);

    // Abort after 7 bytes (one word written plus one byte of the next), then resend.
    fill_random(2);
    do_reset();
    exp_q.push_back('{addr: AW'(0), data: img_words[0]});
    send_byte(8'h02, 0, 0, ok);
    send_byte(8'h00, 0, 0, ok);
    for (int k = 0; k < 4; k++) send_byte(img_words[0][8*k +: 8], 0, 1, ok);
    send_byte(img_words[1][7:0], 0, 0, ok);
    repeat (3) @(posedge clock);
    #1;
    check("abort_first_write", 32'(exp_q.size()), 32'd0);
    $display("image aborted after 7 bytes");
    run_image(2, 0, 0, 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    img_words = '{32'h44332211};
    run_image(1, 0, 0, 0);
    run_image(1, 1, 0, 0);
`endif

    for (int i = 0; i < 10; i++) begin
      r = int'($urandom_range(9, 0));
      if (r == 0)      n = 0;
      else if (r == 1) n = int'($urandom_range(65535, DEPTH + 1));
      else             n = int'($urandom_range(6, 1));
      if (n <= DEPTH) fill_random(n);
      run_image(n, bit'($urandom_range(1, 0)), 0, int'($urandom_range(2, 0)));
    end

    fill_random(DEPTH);
    run_image(DEPTH, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
